// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake bundle between the fetch unit (master) and the
// instruction memory (slave).
interface fetch_unit_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
);
  logic              req;
  logic [PC_W-1:0]   addr;
  logic              ack;
  logic [INST_W-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD/HALT sequencer with jump/branch PC update.
// Optional feature macro: FETCH_HALT_EN (retiring OP=4'hF parks the unit in HALT).
module fetch_unit #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch,
  output logic [INST_W-1:0] inst,
  output logic [3:0]        op,
  output logic              inst_valid,
  output logic [PC_W-1:0]   pc,
  output logic              halted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_nxt_s;
  logic [PC_W-1:0]   retire_pc_s;
  logic [INST_W-1:0] inst_r;
  logic [INST_W-1:0] inst_nxt_s;
  logic              valid_r;
  logic              valid_nxt_s;
  logic              req_r;
  logic              halt_op_s;

  function automatic logic [PC_W-1:0] sext_imm(input logic [7:0] imm);
    return PC_W'($signed(imm));
  endfunction

`ifdef FETCH_HALT_EN
  assign halt_op_s = (inst_r[15:12] == 4'hF);
`else
  assign halt_op_s = 1'b0;
`endif

  // Next-PC selection for a retiring instruction; jump outranks branch.
  always_comb begin
    if (jump) begin
      retire_pc_s = inst_r[PC_W-1:0];
    end else if (branch) begin
      retire_pc_s = pc_r + PC_ONE + sext_imm(inst_r[7:0]);
    end else begin
      retire_pc_s = pc_r + PC_ONE;
    end
  end

  // Sequencer next-state and datapath next values.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    inst_nxt_s  = inst_r;
    valid_nxt_s = valid_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.ack) begin
          inst_nxt_s  = imem.data;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          valid_nxt_s = 1'b0;
          // A halting instruction leaves the PC parked at its own address.
          if (halt_op_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            pc_nxt_s    = retire_pc_s;
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= {PC_W{1'b0}};
      inst_r  <= {INST_W{1'b0}};
      valid_r <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      inst_r  <= inst_nxt_s;
      valid_r <= valid_nxt_s;
      req_r   <= (state_nxt_s == ST_FETCH);
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_r;

  // Registered halt indicator, mirrors entry into HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= (state_nxt_s == ST_HALT);
    end
  end

  assign halted = halted_r;
`else
  assign halted = 1'b0;
`endif

  assign imem.req   = req_r;
  assign imem.addr  = pc_r;
  assign inst       = inst_r;
  assign op         = inst_r[15:12];
  assign inst_valid = valid_r;
  assign pc         = pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// instruction words, an independent negedge monitor pops and compares them.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic        branch;
  logic [15:0] inst;
  logic [3:0]  op;
  logic        inst_valid;
  logic [7:0]  pc;
  logic        halted;

  fetch_unit_if #(.PC_W(8), .INST_W(16)) imem_bus ();

  fetch_unit #(.PC_W(8), .INST_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem_bus),
    .stall      (stall),
    .jump       (jump),
    .branch     (branch),
    .inst       (inst),
    .op         (op),
    .inst_valid (inst_valid),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          addr_q[$];
  logic [15:0] inst_q[$];
  int          ipc_q[$];
  int          new_cyc_q[$];
  int          cyc = 0;
  int          model_pc = 0;
  logic        prev_valid = 1'b0;
  logic        halt_exp = 1'b0;
  logic [15:0] held_inst = 16'h0000;
  logic [7:0]  held_pc = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    32'(pc),            32'd0);
    chk({tag, "_inst"},  32'(inst),          32'd0);
    chk({tag, "_op"},    32'(op),            32'd0);
    chk({tag, "_valid"}, 32'(inst_valid),    32'd0);
    chk({tag, "_req"},   32'(imem_bus.req),  32'd0);
    chk({tag, "_addr"},  32'(imem_bus.addr), 32'd0);
    chk({tag, "_halt"},  32'(halted),        32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_bus.req) begin
        if (addr_q.size() == 0) begin
          note_fail("unexpected_req", 32'(imem_bus.addr), 32'hFFFF_FFFF);
        end else begin
          chk("fetch_addr", 32'(imem_bus.addr), 32'(addr_q[0]));
          if (imem_bus.ack) void'(addr_q.pop_front());
        end
      end
      if (inst_valid && !prev_valid) begin
        if (inst_q.size() == 0) begin
          note_fail("unexpected_inst", 32'(inst), 32'hFFFF_FFFF);
        end else begin
          logic [15:0] w;
          w = inst_q.pop_front();
          chk("inst", 32'(inst), 32'(w));
          chk("op", 32'(op), 32'(w[15:12]));
          chk("inst_pc", 32'(pc), 32'(ipc_q.pop_front()));
        end
        held_inst = inst;
        held_pc   = pc;
        new_cyc_q.push_back(cyc);
      end else if (inst_valid) begin
        chk("hold_inst", 32'(inst), 32'(held_inst));
        chk("hold_pc", 32'(pc), 32'(held_pc));
      end
      if (inst_valid) chk("req_low_in_hold", 32'(imem_bus.req), 32'd0);
      chk("halted", 32'(halted), 32'(halt_exp));
      prev_valid = inst_valid;
    end
  end

  // One instruction: wait for request, optional wait states, ack, optional stall, retire.
  task automatic do_inst(input logic [15:0] word, input int dly, input int stl,
                         input logic j, input logic b);
    int   n;
    int   nxt;
    int   imm;
    logic halting;
    n       = 0;
    halting = 1'b0;
    while (!imem_bus.req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_bus.req) note_fail("req_timeout", 32'(imem_bus.req), 32'd1);
    for (int k = 0; k < dly; k++) begin
      jump   = 1'($urandom);
      branch = 1'($urandom);
      @(posedge clk); #1;
    end
    jump          = 1'b0;
    branch        = 1'b0;
    imem_bus.ack  = 1'b1;
    imem_bus.data = word;
    inst_q.push_back(word);
    ipc_q.push_back(model_pc);
    @(posedge clk); #1;
    imem_bus.ack = 1'b0;
    for (int k = 0; k < stl; k++) begin
      stall         = 1'b1;
      imem_bus.ack  = 1'($urandom);
      imem_bus.data = 16'($urandom);
      jump          = 1'($urandom);
      branch        = 1'($urandom);
      @(posedge clk); #1;
    end
    stall        = 1'b0;
    imem_bus.ack = 1'b0;
    jump         = j;
    branch       = b;
`ifdef FETCH_HALT_EN
    if (word[15:12] == 4'hF) halting = 1'b1;
`endif
    if (!halting) begin
      imm = int'(word[7:0]);
      if (imm > 127) imm = imm - 256;
      if (j)      nxt = int'(word[7:0]);
      else if (b) nxt = (((model_pc + 1 + imm) % 256) + 256) % 256;
      else        nxt = (model_pc + 1) % 256;
      model_pc = nxt;
      addr_q.push_back(nxt);
    end
    @(posedge clk); #1;
    jump   = 1'b0;
    branch = 1'b0;
    if (halting) halt_exp = 1'b1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15:12] = 4'hE;
    return w;
  endfunction

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    jump          = 1'b0;
    branch        = 1'b0;
    imem_bus.ack  = 1'b0;
    imem_bus.data = 16'h0000;
    #12;
    check_reset_vals("por");
    addr_q.push_back(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back zero-wait fetches: addresses 0..3, one instruction per two cycles.
    for (int i = 0; i < 4; i++) do_inst(16'h1000 + 16'(i), 0, 0, 1'b0, 1'b0);
    if (new_cyc_q.size() >= 4) begin
      for (int i = 0; i < 3; i++) chk("throughput_gap", 32'(new_cyc_q[i+1] - new_cyc_q[i]), 32'd2);
    end else begin
      note_fail("throughput_count", 32'(new_cyc_q.size()), 32'd4);
    end

    do_inst(rand_word(), 3, 5, 1'b0, 1'b0);
    do_inst(16'h0010, 0, 0, 1'b1, 1'b0);
    do_inst(16'h20FE, 1, 0, 1'b0, 1'b1);
    do_inst(16'h0010, 0, 0, 1'b1, 1'b0);
    do_inst(16'h3040, 0, 2, 1'b1, 1'b1);
    do_inst(16'h00FF, 0, 0, 1'b1, 1'b0);
    do_inst(16'h1234, 0, 0, 1'b0, 1'b0);
    do_inst(rand_word(), 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_inst(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset while a request is outstanding.
    #2;
    chk("pre_reset_req", 32'(imem_bus.req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    addr_q.delete();
    inst_q.delete();
    ipc_q.delete();
    model_pc = 0;
    addr_q.push_back(0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) do_inst(rand_word(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);

    do_inst(16'h0005, 0, 0, 1'b1, 1'b0);
    do_inst(16'hF000, 0, 0, 1'b0, 1'b0);
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 6; i++) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_pc", 32'(pc), 32'd5);
      chk("halt_req", 32'(imem_bus.req), 32'd0);
      @(posedge clk); #1;
    end
`else
    chk("after_f000_addr", 32'(imem_bus.addr), 32'd6);
    do_inst(rand_word(), 0, 0, 1'b0, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("inst_queue_drained", 32'(inst_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 8, SHALL set the program counter and instruction-memory address width in bits.
REQ-002 Parameter INST_W, default 16, SHALL set the instruction word width; fields are OP=[15:12], RA=[11:10], RB=[9:8], IMM=[7:0].
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 IMEM_REQ  output  1  SHALL be the instruction-memory read request.
REQ-006 IMEM_ADDR  output  PC_W  SHALL be the fetch address; it equals PC.
REQ-007 IMEM_ACK  input  1  SHALL be the memory acknowledge; IMEM_DATA is valid in the same cycle.
REQ-008 IMEM_DATA  input  INST_W  SHALL be the fetched instruction word.
REQ-009 STALL  input  1  SHALL be the downstream hold; while high, the current instruction does not retire.
REQ-010 JUMP  input  1  SHALL be the jump decision from the control unit for the current instruction.
REQ-011 BRANCH  input  1  SHALL be the taken-branch decision from the control unit for the current instruction.
REQ-012 INST  output  INST_W  SHALL be the registered current instruction.
REQ-013 OP  output  4  SHALL equal INST[15:12] and feed the control unit.
REQ-014 INST_VALID  output  1  SHALL be high while INST holds an unretired instruction.
REQ-015 PC  output  PC_W  SHALL be the address of the current or pending instruction.
REQ-016 HALTED  output  1  SHALL be high while the halt state is held (REQ-031); tied low when that feature is not compiled in.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, HOLD and HALT; IMEM_REQ SHALL be high only in FETCH.
REQ-018 IDLE SHALL advance to FETCH on the first rising edge after RST_N deasserts.
REQ-019 In FETCH, IMEM_ADDR SHALL remain stable at PC until IMEM_ACK is sampled high.
REQ-020 An IMEM_ACK sampled high in FETCH SHALL load INST from IMEM_DATA, set INST_VALID and enter HOLD on that edge.
REQ-021 An acknowledge in the same cycle that IMEM_REQ rises SHALL be accepted, giving one-cycle fetch latency.
REQ-022 An IMEM_ACK sampled high outside FETCH SHALL be ignored.
REQ-023 In HOLD with STALL low, the instruction SHALL retire on the edge: the PC updates, INST_VALID clears and the FSM enters FETCH.
REQ-024 In HOLD with STALL high, INST, PC and INST_VALID SHALL hold, for any number of cycles.
REQ-025 JUMP and BRANCH SHALL be sampled only on a retire edge and ignored otherwise.
REQ-026 On retire, the next PC SHALL be selected as follows:
- JUMP high: next PC = INST[PC_W-1:0].
- Else BRANCH high: next PC = PC + 1 + sign-extended IMM.
- Else: next PC = PC + 1.
REQ-027 When JUMP and BRANCH are both high on a retire edge, JUMP SHALL take priority.
REQ-028 All PC arithmetic SHALL be modulo 2^PC_W, so the PC wraps around silently.
REQ-029 Minimum throughput SHALL be one instruction per two cycles (one FETCH cycle plus one HOLD cycle).

Reset
REQ-030 Asserting RST_N low at any time, including mid-fetch or mid-stall, SHALL immediately force the following and abandon any pending request:
- State = IDLE.
- PC = 0, INST = 0, OP = 0.
- INST_VALID = 0, IMEM_REQ = 0, HALTED = 0.

Configuration
REQ-031 Macro FETCH_HALT_EN defined: retiring an instruction with OP=4'hF SHALL enter HALT with HALTED=1, PC frozen at the halt address and IMEM_REQ low until reset. Macro absent: OP=4'hF SHALL retire as a normal sequential instruction, HALT SHALL be unreachable and HALTED SHALL be tied to 0.

Verification
REQ-032 Sequential fetch: release reset, ACK in the same cycle as every REQ with words 16'h1000..16'h1003, STALL=0 -> IMEM_ADDR sequence is 0,1,2,3 and INST_VALID is high on alternate cycles.
REQ-033 Wait states and stall:
- ACK delayed 3 cycles -> IMEM_ADDR is held stable for 4 cycles.
- STALL high for 5 cycles in HOLD -> INST and PC are unchanged for those cycles.
REQ-034 Control flow:
- PC=8'h10 with IMM=8'hFE, BRANCH=1 -> next PC = 8'h0F.
- PC=8'h10, JUMP=1 and BRANCH=1, INST[7:0]=8'h40 -> next PC = 8'h40.
- JUMP pulsed outside a retire edge -> no effect on PC.
REQ-035 Wrap-around: PC=8'hFF retiring sequentially -> next PC = 8'h00.
REQ-036 Reset mid-operation: RST_N pulled low during FETCH with IMEM_REQ high -> all outputs immediately return to the REQ-030 values and fetching restarts at address 0.
REQ-037 Halt: with FETCH_HALT_EN defined, retire 16'hF000 at PC=5 -> HALTED=1, PC=5 and IMEM_REQ=0 persist; without the macro, the same stimulus fetches address 6.
